multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the simple processor datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and issues one-cycle write enables for the instruction register, PC, register file and data memory. It also runs the start/ready handshake with the iterative multiply/divide unit for R-type `mul`/`div`, enforces a timeout on that unit, and counts retired instructions. The block sits between instruction memory and the existing combinational decode/datapath. It owns only *when* state elements update; datapath muxing stays in the decode logic.

## Interface
- MD_TIMEOUT, default 40: maximum cycles spent in MD_WAIT before abort.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; one clock domain.
- run, input, 1: when 0, the sequencer holds in FETCH without fetching.
- opcode, input, 5: instruction bits [31:27], valid from DECODE onward (IR output).
- aluop, input, 5: instruction bits [6:2], valid from DECODE onward.
- md_ready, input, 1: multdiv result valid; a single-cycle pulse.
- md_exception, input, 1: multdiv exception; sampled only with md_ready.
- ir_we, output, 1: latch the instruction register.
- pc_we, output, 1: commit the next PC; the datapath selects +1, branch or jump target.
- rf_we, output, 1: register-file write.
- dm_we, output, 1: data-memory write.
- ctrl_mult, output, 1: one-cycle multiply start pulse.
- ctrl_div, output, 1: one-cycle divide start pulse.
- md_exc, output, 1: sticky flag, set on md_exception or timeout.
- state, output, 3: current state encoding.
- instr_count, output, CNT_W: number of retired instructions.

## Operation
State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MD_WAIT=5. Codes 6 and 7 are illegal and return to FETCH on the next edge.

Opcode classes:
- R-type = 00000.
- j = 00001, bne = 00010, jal = 00011, jr = 00100, blt = 00110.
- addi = 00101, sw = 00111, lw = 01000.
- mul = R-type with aluop 00110; div = R-type with aluop 00111.
- Any other opcode is a NOP.

State transitions:
- **FETCH**: if run=1, assert ir_we and go to DECODE. Otherwise stay in FETCH with all enables low.
- **DECODE**: always go to EXEC. No enables asserted.
- **EXEC**, by class:
  - R-type (not mul/div) and addi: go to WB.
  - mul: pulse ctrl_mult, go to MD_WAIT. div: pulse ctrl_div, go to MD_WAIT.
  - lw and sw: go to MEM.
  - j, bne, blt, jr: assert pc_we, retire, go to FETCH.
  - jal: assert pc_we and rf_we (write $r31), retire, go to FETCH.
  - NOP: assert pc_we, retire, go to FETCH.
- **MEM**:
  - sw: assert dm_we and pc_we, retire, go to FETCH.
  - lw: go to WB.
- **MD_WAIT**: a wait counter is cleared on entry and increments each cycle.
  - md_ready=1: go to WB. If md_exception=1 on that cycle, set md_exc.
  - Counter reaches MD_TIMEOUT−1 with no md_ready: set md_exc, assert pc_we only (no register write), retire, go to FETCH.
  - md_ready arriving on the timeout cycle takes priority: the result is written normally.
- **WB**: assert rf_we and pc_we, retire, go to FETCH.

Retire and flag rules:
- "Retire" means instr_count increments by 1 on that edge.
- instr_count wraps modulo 2^CNT_W.
- md_exc is cleared only by reset.

## Timing
- All outputs are Moore-style, decoded from state plus the registered opcode/aluop. No input-to-output combinational path except opcode/aluop.
- Reset values: state=FETCH, instr_count=0, md_exc=0, wait counter=0. All enables and start pulses are 0 while reset is low.
- Reset asserted mid-instruction aborts it: no enable fires after reset asserts, and the instruction does not retire.
- Cycles per instruction, from FETCH entry to the next FETCH entry:
  - branch/jump/NOP: 3.
  - sw: 4.
  - ALU/addi: 4.
  - lw: 5.
  - mul/div: 4 + wait cycles.
- Exactly one pc_we pulse per instruction. ir_we occurs only in FETCH.
- ctrl_mult/ctrl_div are high for exactly one cycle per mul/div and are never asserted together.
- run dropping is honoured only at FETCH; an instruction in flight completes.

## Test plan
- **addi then lw**, run=1: states 0,1,2,4 then 0,1,2,3,4. rf_we high in cycles 4 and 9. instr_count=2 after cycle 9.
- **sw**: dm_we high exactly once, in MEM (cycle 4). pc_we in the same cycle. rf_we never asserted.
- **mul with md_ready 10 cycles after ctrl_mult**: ctrl_mult high for 1 cycle, MD_WAIT for 10 cycles, then WB with rf_we. md_exc stays 0.
- **div with md_ready never asserted**, MD_TIMEOUT=40: leaves MD_WAIT after 40 cycles with md_exc=1. rf_we stays 0, pc_we pulses once, instr_count increments.
- **jal, then opcode 11111 (NOP)**: each takes 3 cycles. jal asserts rf_we+pc_we in EXEC; the NOP asserts only pc_we. Toggling run=0 during the NOP's DECODE still completes it, then holds in FETCH.
- **reset pulled low during MEM of sw, and separately instr_count preloaded near wrap**:
  - Reset during MEM: dm_we never asserts, state=0, instr_count=0 asynchronously.
  - Counter at 0xFFFFFFFF: retiring one more instruction gives 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for the simple processor datapath. Each instruction
// is stepped through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block only
// decides *when* the instruction register, PC, register file and data memory
// update. It also starts the iterative multiply/divide unit, bounds the wait
// for its result, and counts retired instructions.
//
// Parameters:
//   MD_TIMEOUT   maximum number of cycles spent in MD_WAIT before abort
//   CNT_W        width of the retired-instruction counter (wraps)
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   run          1 = keep fetching; sampled on the edge that enters FETCH
//   opcode       instruction bits [31:27] from the IR (valid from DECODE on)
//   aluop        instruction bits [6:2] from the IR (valid from DECODE on)
//   md_ready     multiply/divide result valid (single-cycle pulse)
//   md_exception multiply/divide exception, qualified by md_ready
//   ir_we        latch the instruction register
//   pc_we        commit the next PC (exactly one pulse per instruction)
//   rf_we        register-file write
//   dm_we        data-memory write
//   ctrl_mult    one-cycle multiply start pulse
//   ctrl_div     one-cycle divide start pulse
//   md_exc       sticky multiply/divide exception or timeout flag
//   state        current state code (FETCH=0 ... MD_WAIT=5)
//   instr_count  number of retired instructions, modulo 2^CNT_W
//
// All outputs come straight from flops. Every enable is computed for the
// state being entered, so it is high for exactly the cycle spent in that
// state and is cleared immediately by reset.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluop,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             dm_we,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_exc,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_MD_WAIT = 3'd5
  } state_t;

  // Opcode map
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // The wait counter only has to reach MD_TIMEOUT-1.
  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Instruction class decode (from the IR-held opcode/aluop)
  // ---------------------------------------------------------------------------
  logic is_rtype;
  logic is_mul;
  logic is_div;
  logic is_alu;
  logic is_lw;
  logic is_sw;
  logic is_branch;
  logic is_jal;
  logic is_nop;

  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_mul    = is_rtype && (aluop == ALU_MUL);
    is_div    = is_rtype && (aluop == ALU_DIV);
    is_alu    = (is_rtype && !is_mul && !is_div) || (opcode == OP_ADDI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_branch = (opcode == OP_J) || (opcode == OP_BNE) ||
                (opcode == OP_JR) || (opcode == OP_BLT);
    is_jal    = (opcode == OP_JAL);
    is_nop    = !is_rtype && !is_alu && !is_lw && !is_sw &&
                !is_branch && !is_jal;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               md_exc_q, md_exc_d;
  logic               ir_we_q, ir_we_d;
  logic               pc_we_q, pc_we_d;
  logic               rf_we_q, rf_we_d;
  logic               dm_we_q, dm_we_d;
  logic               mult_q, mult_d;
  logic               div_q, div_d;
  logic               retire;

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    md_exc_d = md_exc_q;
    retire   = 1'b0;

    // ---- next state ----
    case (state_q)
      ST_FETCH: begin
        // ir_we_q high means the instruction is being latched this cycle.
        if (ir_we_q) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_alu) begin
          state_d = ST_WB;
        end else if (is_mul || is_div) begin
          state_d = ST_MD_WAIT;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          // branches, jumps, jal and NOPs complete here
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end

      ST_MEM: begin
        if (is_lw) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end

      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end

      ST_MD_WAIT: begin
        // A result on the final wait cycle still wins over the timeout.
        if (md_ready) begin
          state_d = ST_WB;
          if (md_exception) begin
            md_exc_d = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d  = ST_FETCH;
          md_exc_d = 1'b1;
          retire   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        // unreachable codes 6 and 7 fall back to FETCH without retiring
        state_d = ST_FETCH;
      end
    endcase

    count_d = retire ? (count_q + 1'b1) : count_q;

    // ---- enables for the state being entered ----
    ir_we_d = 1'b0;
    pc_we_d = 1'b0;
    rf_we_d = 1'b0;
    dm_we_d = 1'b0;
    mult_d  = 1'b0;
    div_d   = 1'b0;

    case (state_d)
      ST_FETCH: begin
        ir_we_d = run;
      end

      ST_EXEC: begin
        mult_d  = is_mul;
        div_d   = is_div;
        pc_we_d = is_branch || is_jal || is_nop;
        rf_we_d = is_jal;
      end

      ST_MEM: begin
        dm_we_d = is_sw;
        pc_we_d = is_sw;
      end

      ST_WB: begin
        rf_we_d = 1'b1;
        // If the PC was already committed on the timeout cycle (result
        // arrived on that same cycle), do not commit it a second time.
        pc_we_d = !((state_q == ST_MD_WAIT) && pc_we_q);
      end

      ST_MD_WAIT: begin
        // The last permitted wait cycle commits the PC for the abort path.
        pc_we_d = (wait_d == WAIT_LAST);
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      wait_q   <= '0;
      count_q  <= '0;
      md_exc_q <= 1'b0;
      ir_we_q  <= 1'b0;
      pc_we_q  <= 1'b0;
      rf_we_q  <= 1'b0;
      dm_we_q  <= 1'b0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      md_exc_q <= md_exc_d;
      ir_we_q  <= ir_we_d;
      pc_we_q  <= pc_we_d;
      rf_we_q  <= rf_we_d;
      dm_we_q  <= dm_we_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign md_exc      = md_exc_q;
  assign ir_we       = ir_we_q;
  assign pc_we       = pc_we_q;
  assign rf_we       = rf_we_q;
  assign dm_we       = dm_we_q;
  assign ctrl_mult   = mult_q;
  assign ctrl_div    = div_q;

endmodule
